// File: rtl/esm_instr_feeder_if.sv
// Fetch-to-feeder instruction channel: fetch drives valid/instr, the feeder returns ready.
// A word transfers on any rising edge where fetch_valid && fetch_ready are both high.
interface esm_instr_feeder_if #(
    parameter int Instruction_word_size = 32
);
    logic                             fetch_valid;
    logic [Instruction_word_size-1:0] fetch_instr;
    logic                             fetch_ready;

    modport master (output fetch_valid, output fetch_instr, input fetch_ready);
    modport slave  (input fetch_valid, input fetch_instr, output fetch_ready);
endinterface

// File: rtl/esm_instr_feeder.sv
// ESM feed stage: FIFO-buffers fetched RV32I words, predecodes RegWrite/ALUSrc, emits one per cycle.
// Optional macro ESM_FEED_RD0_SUPPRESS_EN forces RegWrite low for any word with rd == x0.
module esm_instr_feeder #(
    parameter int Instruction_word_size = 32,
    parameter int DEPTH                 = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    esm_instr_feeder_if.slave                fetch,
    input  logic                             hold,
    input  logic                             flush,
    output logic [Instruction_word_size-1:0] Instr_out,
    output logic                             RegWrite,
    output logic                             ALUSrc,
    output logic                             out_valid,
    output logic [$clog2(DEPTH):0]           count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [Instruction_word_size-1:0] mem [DEPTH];
    logic [PW-1:0]                    wr_ptr;
    logic [PW-1:0]                    rd_ptr;

    logic                             push;
    logic                             empty;
    logic                             pop;
    logic                             bypass;
    logic                             fifo_wr;
    logic [Instruction_word_size-1:0] load_word;
    logic [1:0]                       load_pd;
    logic                             load_rw;
    logic                             load_alu;

    // Returns {RegWrite, ALUSrc} for an RV32I opcode.
    function automatic logic [1:0] predecode(input logic [6:0] opcode);
        logic [1:0] pd;
        pd = 2'b00;
        case (opcode)
            7'b0110011: pd = 2'b10;
            7'b0010011: pd = 2'b11;
            7'b0000011: pd = 2'b11;
            7'b0110111: pd = 2'b11;
            7'b0010111: pd = 2'b11;
            7'b1100011: pd = 2'b00;
            7'b0100011: pd = 2'b01;
            7'b1101111: pd = 2'b10;
            7'b1100111: pd = 2'b11;
            default:    pd = 2'b00;
        endcase
        return pd;
    endfunction

    always_comb begin
        // Ready is based on registered occupancy only; a same-cycle pop does not free a slot.
        fetch.fetch_ready = !rst && (count != CW'(DEPTH));
        push      = fetch.fetch_valid && fetch.fetch_ready;
        empty     = (count == '0);
        pop       = !flush && !hold && !empty;
        bypass    = !flush && !hold && empty && push;
        fifo_wr   = push && !flush && !bypass;
        load_word = '0;
        if (pop)
            load_word = mem[rd_ptr];
        else if (bypass)
            load_word = fetch.fetch_instr;
        load_pd   = predecode(load_word[6:0]);
`ifdef ESM_FEED_RD0_SUPPRESS_EN
        load_rw   = load_pd[1] && (load_word[11:7] != 5'd0);
`else
        load_rw   = load_pd[1];
`endif
        load_alu  = load_pd[0];
    end

    always_ff @(posedge clk) begin
        if (fifo_wr)
            mem[wr_ptr] <= fetch.fetch_instr;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (fifo_wr)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({fifo_wr, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Flush loads an all-zero word, which predecodes to a clean bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            Instr_out <= '0;
            RegWrite  <= 1'b0;
            ALUSrc    <= 1'b0;
            out_valid <= 1'b0;
        end else if (flush || !hold) begin
            Instr_out <= load_word;
            RegWrite  <= load_rw;
            ALUSrc    <= load_alu;
            out_valid <= pop || bypass;
        end
    end

endmodule

// File: tb/tb_esm_instr_feeder.sv
// Randomized scoreboard bench for esm_instr_feeder with directed scenarios first.
// Honours ESM_FEED_RD0_SUPPRESS_EN in its reference predecode.
module tb_esm_instr_feeder;
    localparam int W     = 32;
    localparam int DEPTH = 4;

    logic           clk;
    logic           rst;
    logic           hold;
    logic           flush;
    logic [W-1:0]   Instr_out;
    logic           RegWrite;
    logic           ALUSrc;
    logic           out_valid;
    logic [2:0]     count;

    esm_instr_feeder_if #(.Instruction_word_size(W)) fetch_if ();

    esm_instr_feeder #(.Instruction_word_size(W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .fetch     (fetch_if.slave),
        .hold      (hold),
        .flush     (flush),
        .Instr_out (Instr_out),
        .RegWrite  (RegWrite),
        .ALUSrc    (ALUSrc),
        .out_valid (out_valid),
        .count     (count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // scoreboard state: expected {instr, RegWrite, ALUSrc} in delivery order
    logic [W+1:0] exp_q[$];
    int           m_cnt     = 0;
    int           exp_count = 0;
    logic         exp_valid = 1'b0;

    logic [6:0] op_tab [10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0110111, 7'b0010111,
                                7'b1100011, 7'b0100011, 7'b1101111, 7'b1100111, 7'b1110011};
    logic [1:0] pd_tab [10] = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b11,
                                2'b00, 2'b01, 2'b10, 2'b11, 2'b00};

    function automatic logic [W+1:0] ref_resp(input logic [W-1:0] w);
        logic [1:0] pd;
        logic [6:0] op;
        logic [4:0] rd;
        op = w[6:0];
        rd = w[11:7];
        pd = 2'b00;
        for (int i = 0; i < 10; i++)
            if (op_tab[i] == op) pd = pd_tab[i];
`ifdef ESM_FEED_RD0_SUPPRESS_EN
        if (rd == 5'd0) pd[1] = 1'b0;
`endif
        return {w, pd};
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // driver: apply one cycle of inputs and advance the reference model to the post-edge state
    task automatic step(input logic v, input logic [W-1:0] w, input logic h, input logic f,
                        input logic r);
        logic acc;
        @(negedge clk);
        fetch_if.fetch_valid = v;
        fetch_if.fetch_instr = w;
        hold  = h;
        flush = f;
        rst   = r;
        acc   = v && !r && (m_cnt != DEPTH);
        if (r) begin
            exp_q.delete();
            m_cnt     = 0;
            exp_valid = 1'b0;
        end else if (f) begin
            exp_q.delete();
            m_cnt     = 0;
            exp_valid = 1'b0;
        end else if (h) begin
            if (acc) begin
                exp_q.push_back(ref_resp(w));
                m_cnt++;
            end
        end else if (m_cnt != 0) begin
            m_cnt--;
            exp_valid = 1'b1;
            if (acc) begin
                exp_q.push_back(ref_resp(w));
                m_cnt++;
            end
        end else if (acc) begin
            exp_q.push_back(ref_resp(w));
            exp_valid = 1'b1;
        end else begin
            exp_valid = 1'b0;
        end
        exp_count = m_cnt;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // monitor: compares DUT outputs after every edge against the scoreboard
    logic [W-1:0] prev_instr = '0;
    logic         prev_rw    = 1'b0;
    logic         prev_alu   = 1'b0;
    logic         prev_valid = 1'b0;

    always @(posedge clk) begin : monitor
        logic         s_rst;
        logic         s_hold;
        logic         s_flush;
        logic [W+1:0] e;
        s_rst   = rst;
        s_hold  = hold;
        s_flush = flush;
        #1;
        chk("count", W'(count), W'(exp_count));
        chk("out_valid", W'(out_valid), W'(exp_valid));
        chk("fetch_ready", W'(fetch_if.fetch_ready), W'(!rst && (exp_count != DEPTH)));
        if (s_rst || !out_valid) begin
            chk("bubble_instr", Instr_out, '0);
            chk("bubble_pd", W'({RegWrite, ALUSrc}), '0);
        end else if (s_hold && !s_flush) begin
            chk("hold_instr", Instr_out, prev_instr);
            chk("hold_pd", W'({RegWrite, ALUSrc, out_valid}), W'({prev_rw, prev_alu, prev_valid}));
        end else if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL order: got unexpected word 0x%0h expected none at %0t", Instr_out, $time);
        end else begin
            e = exp_q.pop_front();
            chk("instr", Instr_out, e[W+1:2]);
            chk("regwrite", W'(RegWrite), W'(e[1]));
            chk("alusrc", W'(ALUSrc), W'(e[0]));
        end
        prev_instr = Instr_out;
        prev_rw    = RegWrite;
        prev_alu   = ALUSrc;
        prev_valid = out_valid;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] w;
        logic [W-1:0] s3_words [4] = '{32'h002081B3, 32'h00A2E063, 32'h0042A423, 32'h004000EF};
        logic [1:0]   s3_pd    [4] = '{2'b10, 2'b00, 2'b01, 2'b10};

        rst = 1'b1;
        hold = 1'b0;
        flush = 1'b0;
        fetch_if.fetch_valid = 1'b0;
        fetch_if.fetch_instr = '0;
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        settle();
        chk("rst_out", Instr_out, '0);
        chk("rst_ready", W'(fetch_if.fetch_ready), '0);
        idle(1);

        // addi bypass into an empty FIFO
        step(1'b1, 32'h00A00093, 1'b0, 1'b0, 1'b0);
        settle();
        chk("t1_instr", Instr_out, 32'h00A00093);
        chk("t1_pd", W'({RegWrite, ALUSrc, out_valid}), W'(3'b111));
        chk("t1_count", W'(count), '0);
        idle(2);

        // hold while offering five words: only four are accepted
        for (int i = 0; i < 5; i++) step(1'b1, 32'h00100013 + W'(i << 7), 1'b1, 1'b0, 1'b0);
        settle();
        chk("t2_full", W'(count), W'(DEPTH));
        chk("t2_ready", W'(fetch_if.fetch_ready), '0);
        idle(6);
        chk("t2_drained", W'(out_valid), '0);

        // predecode over a stream of mixed opcodes
        for (int i = 0; i < 4; i++) begin
            step(1'b1, s3_words[i], 1'b0, 1'b0, 1'b0);
            settle();
            chk("t3_pd", W'({RegWrite, ALUSrc}), W'(s3_pd[i]));
        end
        idle(2);

        // flush with three buffered words and a concurrent push
        for (int i = 0; i < 3; i++) step(1'b1, 32'h00300093 + W'(i << 20), 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'hDEAD00B3, 1'b0, 1'b1, 1'b0);
        settle();
        chk("t4_count", W'(count), '0);
        chk("t4_instr", Instr_out, '0);
        idle(3);

        // reset mid-stream with two buffered words
        for (int i = 0; i < 2; i++) step(1'b1, 32'h00500113 + W'(i << 20), 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h00700193, 1'b0, 1'b0, 1'b1);
        settle();
        chk("t5_ready_rst", W'(fetch_if.fetch_ready), '0);
        idle(1);
        settle();
        chk("t5_ready_after", W'(fetch_if.fetch_ready), W'(1));

        // jalr x0, and an all-zero word accepted from fetch
        step(1'b1, 32'h00008067, 1'b0, 1'b0, 1'b0);
        settle();
`ifdef ESM_FEED_RD0_SUPPRESS_EN
        chk("t6_regwrite", W'(RegWrite), '0);
`else
        chk("t6_regwrite", W'(RegWrite), W'(1));
`endif
        chk("t6_alusrc", W'(ALUSrc), W'(1));
        step(1'b1, 32'h00000000, 1'b0, 1'b0, 1'b0);
        settle();
        chk("zero_word", W'({out_valid, RegWrite, ALUSrc}), W'(3'b100));
        idle(2);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            w = $urandom();
            w[6:0] = op_tab[$urandom_range(0, 9)];
            if ($urandom_range(0, 15) == 0) w[11:7] = 5'd0;
            if ($urandom_range(0, 31) == 0) w = '0;
            step($urandom_range(0, 9) < 7, w, $urandom_range(0, 9) < 3,
                 $urandom_range(0, 39) == 0, $urandom_range(0, 99) == 0);
        end
        idle(DEPTH + 3);
        settle();
        chk("sb_empty", W'(exp_q.size()), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
